// File: rtl/c_nat_split_n_if.sv
// rtl/c_nat_split_n_if.sv - token fork bus: upstream drive/free plus per-branch driveNext/freeNext
interface c_nat_split_n_if #(
  parameter int N_OUT = 2,
  parameter int DW    = 32
);
  logic             drive;
  logic [DW-1:0]    data;
  logic [N_OUT-1:0] mask;
  logic             free;
  logic [N_OUT-1:0] driveNext;
  logic [DW-1:0]    dataNext;
  logic [N_OUT-1:0] freeNext;
  logic             busy;
  logic [N_OUT-1:0] pending;
  logic             err;

  modport master (
    output drive, data, mask, freeNext,
    input  free, driveNext, dataNext, busy, pending, err
  );

  modport slave (
    input  drive, data, mask, freeNext,
    output free, driveNext, dataNext, busy, pending, err
  );
endinterface

// File: rtl/c_nat_split_n.sv
// rtl/c_nat_split_n.sv - N-way natural split: broadcasts one token to selected branches and
// returns a single free once every driven branch has freed it, after FREE_DLY cycles.
module c_nat_split_n #(
  parameter int N_OUT    = 2,
  parameter int DW       = 32,
  parameter int FREE_DLY = 2,
  parameter int MASK_EN  = 1
) (
  input logic            clk,
  input logic            rst,
  c_nat_split_n_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DELAY} state_t;

  localparam int CW = $clog2(FREE_DLY + 1);

  state_t           state;
  logic [CW-1:0]    dlyCnt;
  logic [N_OUT-1:0] pendingR;
  logic [N_OUT-1:0] driveNextR;
  logic [DW-1:0]    dataR;
  logic             freeR;
  logic             errR;

  logic [N_OUT-1:0] eff;
  logic [N_OUT-1:0] remain;
  logic             driveErr;
  logic             freeErr;

  assign eff      = (MASK_EN != 0) ? bus.mask : {N_OUT{1'b1}};
  assign remain   = pendingR & ~bus.freeNext;
  assign driveErr = bus.drive && (state != IDLE);
  assign freeErr  = |(bus.freeNext & ~pendingR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dlyCnt     <= '0;
      pendingR   <= '0;
      driveNextR <= '0;
      dataR      <= '0;
      freeR      <= 1'b0;
      errR       <= 1'b0;
    end else begin
      driveNextR <= '0;
      freeR      <= 1'b0;
      errR       <= driveErr || freeErr;
      case (state)
        IDLE: begin
          if (bus.drive) begin
            dataR      <= bus.data;
            driveNextR <= eff;
            pendingR   <= eff;
            if (eff != '0) begin
              state <= WAIT;
            end else if (FREE_DLY == 1) begin
              // an empty mask finishes on the drive cycle itself
              freeR <= 1'b1;
            end else begin
              state  <= DELAY;
              dlyCnt <= CW'(FREE_DLY - 1);
            end
          end
        end
        WAIT: begin
          pendingR <= remain;
          if (remain == '0) begin
            if (FREE_DLY == 1) begin
              freeR <= 1'b1;
              state <= IDLE;
            end else begin
              state  <= DELAY;
              dlyCnt <= CW'(FREE_DLY - 1);
            end
          end
        end
        DELAY: begin
          // leave DELAY on the same edge that raises free so a coincident drive is accepted
          if (dlyCnt == CW'(1)) begin
            freeR <= 1'b1;
            state <= IDLE;
          end else begin
            dlyCnt <= dlyCnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.free      = freeR;
  assign bus.driveNext = driveNextR;
  assign bus.dataNext  = dataR;
  assign bus.busy      = (state != IDLE);
  assign bus.pending   = pendingR;
  assign bus.err       = errR;
endmodule

// File: tb/tb_c_nat_split_n.sv
// tb/tb_c_nat_split_n.sv - directed checks of c_nat_split_n: an unmasked 2-way fork driven
// from a per-cycle vector table and a masked 4-way fork plus reset cases written by hand.
module tb_c_nat_split_n;
  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  c_nat_split_n_if #(.N_OUT(2), .DW(32)) ifA ();
  c_nat_split_n_if #(.N_OUT(4), .DW(32)) ifB ();

  c_nat_split_n #(.N_OUT(2), .DW(32), .FREE_DLY(2), .MASK_EN(0)) dutA (
    .clk(clk), .rst(rstA), .bus(ifA)
  );
  c_nat_split_n #(.N_OUT(4), .DW(32), .FREE_DLY(2), .MASK_EN(1)) dutB (
    .clk(clk), .rst(rstB), .bus(ifB)
  );

  typedef struct {
    logic        drive;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  freeNext;
    logic [3:0]  expDn;
    logic [31:0] expData;
    logic        expFree;
    logic        expBusy;
    logic        expErr;
    logic [3:0]  expPend;
  } vec_t;

  vec_t tbl[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkA(input string tag, input logic [3:0] dn, input logic [31:0] dat,
                      input logic fr, input logic bs, input logic er, input logic [3:0] pd);
    chk({tag, ".driveNext"}, {30'b0, ifA.driveNext}, {28'b0, dn});
    chk({tag, ".dataNext"}, ifA.dataNext, dat);
    chk({tag, ".free"}, {31'b0, ifA.free}, {31'b0, fr});
    chk({tag, ".busy"}, {31'b0, ifA.busy}, {31'b0, bs});
    chk({tag, ".err"}, {31'b0, ifA.err}, {31'b0, er});
    chk({tag, ".pending"}, {30'b0, ifA.pending}, {28'b0, pd});
  endtask

  task automatic chkB(input string tag, input logic [3:0] dn, input logic [31:0] dat,
                      input logic fr, input logic bs, input logic er, input logic [3:0] pd);
    chk({tag, ".driveNext"}, {28'b0, ifB.driveNext}, {28'b0, dn});
    chk({tag, ".dataNext"}, ifB.dataNext, dat);
    chk({tag, ".free"}, {31'b0, ifB.free}, {31'b0, fr});
    chk({tag, ".busy"}, {31'b0, ifB.busy}, {31'b0, bs});
    chk({tag, ".err"}, {31'b0, ifB.err}, {31'b0, er});
    chk({tag, ".pending"}, {28'b0, ifB.pending}, {28'b0, pd});
  endtask

  task automatic setA(input logic dr, input logic [31:0] dat, input logic [1:0] fn);
    ifA.drive    = dr;
    ifA.data     = dat;
    ifA.mask     = 2'b00;
    ifA.freeNext = fn;
  endtask

  task automatic setB(input logic dr, input logic [31:0] dat, input logic [3:0] mk,
                      input logic [3:0] fn);
    ifB.drive    = dr;
    ifB.data     = dat;
    ifB.mask     = mk;
    ifB.freeNext = fn;
  endtask

  initial begin
    // drive, data, mask, freeNext | driveNext, dataNext, free, busy, err, pending
    tbl[0]  = '{1'b1, 32'hA5, 4'h0, 4'h0, 4'h0, 32'h00, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h3, 32'hA5, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[2]  = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'hA5, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[3]  = '{1'b0, 32'h00, 4'h0, 4'h1, 4'h0, 32'hA5, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[4]  = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'hA5, 1'b0, 1'b1, 1'b0, 4'h2};
    tbl[5]  = '{1'b0, 32'h00, 4'h0, 4'h2, 4'h0, 32'hA5, 1'b0, 1'b1, 1'b0, 4'h2};
    tbl[6]  = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'hA5, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[7]  = '{1'b1, 32'h5A, 4'h0, 4'h0, 4'h0, 32'hA5, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 32'h00, 4'h0, 4'h3, 4'h3, 32'h5A, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[9]  = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'h5A, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'h5A, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[11] = '{1'b1, 32'hC3, 4'h0, 4'h0, 4'h0, 32'h5A, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[12] = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h3, 32'hC3, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[13] = '{1'b1, 32'h3C, 4'h0, 4'h0, 4'h0, 32'hC3, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[14] = '{1'b0, 32'h00, 4'h0, 4'h3, 4'h0, 32'hC3, 1'b0, 1'b1, 1'b1, 4'h3};
    tbl[15] = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'hC3, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[16] = '{1'b0, 32'h00, 4'h0, 4'h1, 4'h0, 32'hC3, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[17] = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'hC3, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[18] = '{1'b0, 32'h00, 4'h0, 4'h0, 4'h0, 32'hC3, 1'b0, 1'b0, 1'b0, 4'h0};

    rstA = 1'b1;
    rstB = 1'b1;
    setA(1'b0, 32'h0, 2'b00);
    setB(1'b0, 32'h0, 4'h0, 4'h0);
    tick();
    tick();
    rstA = 1'b0;
    rstB = 1'b0;
    tick();

    // unmasked fork: staggered frees, coincident drive/free, overlap drive, stray free
    for (int i = 0; i < 19; i++) begin
      chkA($sformatf("tbl%0d", i), tbl[i].expDn, tbl[i].expData, tbl[i].expFree,
           tbl[i].expBusy, tbl[i].expErr, tbl[i].expPend);
      setA(tbl[i].drive, tbl[i].data, tbl[i].freeNext[1:0]);
      tick();
    end

    // reset while a token is outstanding
    setA(1'b1, 32'h77, 2'b00);
    tick();
    chkA("rst.dn", 4'h3, 32'h77, 1'b0, 1'b1, 1'b0, 4'h3);
    setA(1'b0, 32'h0, 2'b00);
    tick();
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    chkA("rst.clear", 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rst.nofree%0d", i), {31'b0, ifA.free}, 32'h0);
    end
    setA(1'b1, 32'h99, 2'b00);
    tick();
    chkA("rst.after", 4'h3, 32'h99, 1'b0, 1'b1, 1'b0, 4'h3);
    setA(1'b0, 32'h0, 2'b11);
    tick();
    setA(1'b0, 32'h0, 2'b00);
    chkA("rst.delay", 4'h0, 32'h99, 1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    chkA("rst.free", 4'h0, 32'h99, 1'b1, 1'b0, 1'b0, 4'h0);

    // masked 4-way fork: free on an undriven branch is an error and changes nothing
    chkB("B.reset", 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    setB(1'b1, 32'h11, 4'b0101, 4'h0);
    tick();
    chkB("B.dn", 4'b0101, 32'h11, 1'b0, 1'b1, 1'b0, 4'b0101);
    setB(1'b0, 32'h0, 4'h0, 4'h0);
    tick();
    setB(1'b0, 32'h0, 4'h0, 4'b0010);
    tick();
    setB(1'b0, 32'h0, 4'h0, 4'h0);
    chkB("B.err", 4'h0, 32'h11, 1'b0, 1'b1, 1'b1, 4'b0101);
    setB(1'b0, 32'h0, 4'h0, 4'b0101);
    tick();
    setB(1'b0, 32'h0, 4'h0, 4'h0);
    chkB("B.delay", 4'h0, 32'h11, 1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    chkB("B.free", 4'h0, 32'h11, 1'b1, 1'b0, 1'b0, 4'h0);
    // empty mask, accepted on the free cycle: no branch drive, free two cycles later
    setB(1'b1, 32'h22, 4'h0, 4'h0);
    tick();
    setB(1'b0, 32'h0, 4'h0, 4'h0);
    chkB("B.empty", 4'h0, 32'h22, 1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    chkB("B.emptyFree", 4'h0, 32'h22, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    chkB("B.idle", 4'h0, 32'h22, 1'b0, 1'b0, 1'b0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
